mem_stage: RTL and testbench

- Memory-access pipeline stage between the EXE/MEM and MEM/WB pipeline registers.
- Consumes the registered EXE/MEM fields and performs loads and stores over a request/acknowledge data-memory bus with variable latency.
- Stalls upstream while an access is outstanding and presents registered results to MEM/WB.
- Includes a wait-timeout watchdog with a sticky error flag.

---
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EXE/MEM and MEM/WB.
// Issues loads/stores on a req/ack bus with variable latency, stalls upstream
// while an access is outstanding, and aborts on a wait-timeout (sticky mem_err).
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses are rejected
// with a one-cycle misalign_err pulse instead of having their low bits cleared.
module mem_stage #(
    parameter int WORD_LEN       = 32,
    parameter int REG_ADDR_LEN   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic [WORD_LEN-1:0]     pc_in,
    input  logic [WORD_LEN-1:0]     alu_res_in,
    input  logic [WORD_LEN-1:0]     st_val_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [WORD_LEN-1:0]     mem_addr,
    output logic [WORD_LEN-1:0]     mem_wdata,
    input  logic                    mem_ack,
    input  logic [WORD_LEN-1:0]     mem_rdata,
    output logic                    stall,
    output logic                    valid_out,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic [WORD_LEN-1:0]     pc_out,
    output logic [WORD_LEN-1:0]     alu_res_out,
    output logic [WORD_LEN-1:0]     mem_data_out,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic                    mem_err,
    output logic                    misalign_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [0:0]              r_state;
    logic [7:0]              r_cnt;

    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [WORD_LEN-1:0]     r_mem_addr;
    logic [WORD_LEN-1:0]     r_mem_wdata;

    logic                    r_valid;
    logic                    r_wb_en;
    logic                    r_mem_r_en;
    logic [WORD_LEN-1:0]     r_pc;
    logic [WORD_LEN-1:0]     r_alu;
    logic [WORD_LEN-1:0]     r_data;
    logic [REG_ADDR_LEN-1:0] r_dest;
    logic                    r_mem_err;
    logic                    r_misalign;

    // Instruction held while its access is in flight.
    logic                    r_l_wb_en;
    logic                    r_l_load;
    logic [WORD_LEN-1:0]     r_l_pc;
    logic [WORD_LEN-1:0]     r_l_alu;
    logic [REG_ADDR_LEN-1:0] r_l_dest;

    logic w_access;
    logic w_is_load;
    logic w_misalign;
    logic w_start;
    logic w_timeout;

    // Load + store together is a store.
    assign w_access  = mem_r_en_in | mem_w_en_in;
    assign w_is_load = mem_r_en_in & ~mem_w_en_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_access & (alu_res_in[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start   = (r_state == S_IDLE) & w_access & ~w_misalign;
    assign w_timeout = (r_state == S_WAIT) & ~mem_ack & (r_cnt == TO_LAST);

    // Stall is also released on the abort cycle so the aborted instruction
    // leaves EXE/MEM rather than being presented again and re-issued.
    assign stall = w_start | ((r_state == S_WAIT) & ~mem_ack & ~w_timeout);

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign valid_out    = r_valid;
    assign wb_en_out    = r_wb_en;
    assign mem_r_en_out = r_mem_r_en;
    assign pc_out       = r_pc;
    assign alu_res_out  = r_alu;
    assign mem_data_out = r_data;
    assign dest_out     = r_dest;
    assign mem_err      = r_mem_err;
    assign misalign_err = r_misalign;

    // FSM, bus request and MEM/WB output bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_valid     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_r_en  <= 1'b0;
            r_pc        <= '0;
            r_alu       <= '0;
            r_data      <= '0;
            r_dest      <= '0;
            r_mem_err   <= 1'b0;
            r_misalign  <= 1'b0;
            r_l_wb_en   <= 1'b0;
            r_l_load    <= 1'b0;
            r_l_pc      <= '0;
            r_l_alu     <= '0;
            r_l_dest    <= '0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= mem_w_en_in;
                        r_mem_addr  <= {alu_res_in[WORD_LEN-1:2], 2'b00};
                        r_mem_wdata <= st_val_in;
                        r_l_wb_en   <= wb_en_in;
                        r_l_load    <= w_is_load;
                        r_l_pc      <= pc_in;
                        r_l_alu     <= alu_res_in;
                        r_l_dest    <= dest_in;
                        // Bubble to MEM/WB while the access is outstanding.
                        r_valid     <= 1'b0;
                        r_wb_en     <= 1'b0;
                        r_mem_r_en  <= 1'b0;
                        r_pc        <= '0;
                        r_alu       <= '0;
                        r_data      <= '0;
                        r_dest      <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_valid    <= 1'b1;
                        r_wb_en    <= wb_en_in & ~w_misalign;
                        r_mem_r_en <= w_is_load;
                        r_pc       <= pc_in;
                        r_alu      <= alu_res_in;
                        r_data     <= '0;
                        r_dest     <= dest_in;
                        r_misalign <= w_misalign;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_valid    <= 1'b1;
                        r_wb_en    <= r_l_wb_en;
                        r_mem_r_en <= r_l_load;
                        r_pc       <= r_l_pc;
                        r_alu      <= r_l_alu;
                        r_data     <= r_l_load ? mem_rdata : '0;
                        r_dest     <= r_l_dest;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        // Abort: complete the instruction without writeback.
                        r_mem_req  <= 1'b0;
                        r_mem_err  <= 1'b1;
                        r_valid    <= 1'b1;
                        r_wb_en    <= 1'b0;
                        r_mem_r_en <= r_l_load;
                        r_pc       <= r_l_pc;
                        r_alu      <= r_l_alu;
                        r_data     <= '0;
                        r_dest     <= r_l_dest;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage (TIMEOUT_CYCLES=4).
// Each instruction is turned into per-cycle expectations from transaction
// rules (issue cycle, ack delay or timeout), checked every negedge.
module tb_mem_stage;
    localparam int W  = 32;
    localparam int RA = 4;
    localparam int TO = 4;
    localparam int NC = 256;
    localparam int NOACK = 99;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [W-1:0]  pc_in, alu_res_in, st_val_in;
    logic [RA-1:0] dest_in;
    logic          mem_req, mem_we;
    logic [W-1:0]  mem_addr, mem_wdata;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          stall, valid_out, wb_en_out, mem_r_en_out;
    logic [W-1:0]  pc_out, alu_res_out, mem_data_out;
    logic [RA-1:0] dest_out;
    logic          mem_err, misalign_err;

    mem_stage #(.WORD_LEN(W), .REG_ADDR_LEN(RA), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .pc_in(pc_in), .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .valid_out(valid_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .pc_out(pc_out), .alu_res_out(alu_res_out),
        .mem_data_out(mem_data_out), .dest_out(dest_out),
        .mem_err(mem_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit        cs, stall;
        bit        cr, req, we;
        bit [31:0] addr, wdata;
        bit        co, valid, wb, rd, mis;
        bit [31:0] pc, alu, data;
        bit [3:0]  dest;
    } exp_t;

    exp_t E [NC];
    int   err_lo  = 1 << 30;
    int   err_hi  = 1 << 30;
    bit   err_chk = 1'b0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, want);
        end
    endfunction

    function automatic void set_stall(int c, bit v);
        if (c < NC) begin E[c].cs = 1'b1; E[c].stall = v; end
    endfunction

    function automatic void set_req(int c, bit v, bit we, bit [31:0] a, bit [31:0] d);
        if (c < NC) begin
            E[c].cr = 1'b1; E[c].req = v; E[c].we = we; E[c].addr = a; E[c].wdata = d;
        end
    endfunction

    function automatic void set_out(int c, bit v, bit wb, bit rd, bit [31:0] pc,
                                    bit [31:0] alu, bit [31:0] data, bit [3:0] dest, bit mis);
        if (c < NC) begin
            E[c].co = 1'b1; E[c].valid = v; E[c].wb = wb; E[c].rd = rd;
            E[c].pc = pc; E[c].alu = alu; E[c].data = data; E[c].dest = dest; E[c].mis = mis;
        end
    endfunction

    // Compare DUT against the expectation table every cycle.
    always @(negedge clk) begin
        if (err_chk && cyc < NC) begin
            if (E[cyc].cs) chk("stall", stall, E[cyc].stall);
            if (E[cyc].cr) begin
                chk("mem_req", mem_req, E[cyc].req);
                if (E[cyc].req) begin
                    chk("mem_we", mem_we, E[cyc].we);
                    chk("mem_addr", mem_addr, E[cyc].addr);
                    chk("mem_wdata", mem_wdata, E[cyc].wdata);
                end
            end
            if (E[cyc].co) begin
                chk("valid_out", valid_out, E[cyc].valid);
                chk("wb_en_out", wb_en_out, E[cyc].wb);
                chk("mem_r_en_out", mem_r_en_out, E[cyc].rd);
                chk("pc_out", pc_out, E[cyc].pc);
                chk("alu_res_out", alu_res_out, E[cyc].alu);
                chk("mem_data_out", mem_data_out, E[cyc].data);
                chk("dest_out", dest_out, E[cyc].dest);
                chk("misalign_err", misalign_err, E[cyc].mis);
            end
            chk("mem_err", mem_err, (cyc >= err_lo && cyc < err_hi) ? 32'd1 : 32'd0);
        end
    end

    // Present one instruction, record its expected behaviour, and drive the
    // bus ack ack_at cycles after issue (NOACK = never).
    task automatic run_instr(input bit wb, input bit rd, input bit wr, input bit [31:0] pc,
                             input bit [31:0] alu, input bit [31:0] st, input bit [3:0] dest,
                             input int ack_at, input bit [31:0] rdata);
        int c0, d;
        bit acc, ld, mis, timed;
        c0  = cyc;
        acc = rd | wr;
        ld  = rd & ~wr;
        mis = ALIGN && acc && (alu[1:0] != 2'b00);
        wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
        pc_in = pc; alu_res_in = alu; st_val_in = st; dest_in = dest;
        if (!acc || mis) begin
            set_stall(c0, 1'b0);
            set_req(c0 + 1, 1'b0, 1'b0, 0, 0);
            set_out(c0 + 1, 1'b1, wb & ~mis, ld, pc, alu, 0, dest, mis);
            mem_ack   = (ack_at == 0);
            mem_rdata = rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end else begin
            timed = !(ack_at >= 1 && ack_at <= TO);
            d     = timed ? TO : ack_at;
            set_stall(c0, 1'b1);
            for (int k = 1; k <= d; k++) begin
                set_stall(c0 + k, k < d);
                set_req(c0 + k, 1'b1, wr, {alu[31:2], 2'b00}, st);
                set_out(c0 + k, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
            end
            set_req(c0 + d + 1, 1'b0, 1'b0, 0, 0);
            set_out(c0 + d + 1, 1'b1, wb & ~timed, ld, pc, alu,
                    (ld && !timed) ? rdata : 32'h0, dest, 1'b0);
            if (timed && err_lo > c0 + d + 1) err_lo = c0 + d + 1;
            for (int k = 0; k <= d; k++) begin
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rdata : 32'h0BAD_0BAD;
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1;
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        pc_in = 0; alu_res_in = 0; st_val_in = 0; dest_in = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("reset valid_out", valid_out, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset mem_err", mem_err, 0);
        chk("reset pc_out", pc_out, 0);
        chk("reset mem_data_out", mem_data_out, 0);
        err_chk = 1'b1;

        // Non-memory op.
        run_instr(1, 0, 0, 32'h10, 32'h55, 32'h0, 4'd3, NOACK, 0);
        chk("nop valid", valid_out, 1);
        chk("nop alu", alu_res_out, 32'h55);
        chk("nop dest", dest_out, 3);

        // Load 0x100, ack 3 cycles after issue.
        run_instr(1, 1, 0, 32'h20, 32'h100, 32'h0, 4'd5, 3, 32'hDEADBEEF);
        chk("load data", mem_data_out, 32'hDEADBEEF);
        chk("load r_en", mem_r_en_out, 1);
        chk("load wb", wb_en_out, 1);

        // Store 0x204 with the earliest ack.
        run_instr(1, 0, 1, 32'h24, 32'h204, 32'hCAFEF00D, 4'd0, 1, 32'h77777777);
        chk("store data", mem_data_out, 0);
        chk("store r_en", mem_r_en_out, 0);

        // Back-to-back loads, second without writeback.
        run_instr(1, 1, 0, 32'h28, 32'h300, 32'h0, 4'd6, 1, 32'h01020304);
        run_instr(0, 1, 0, 32'h2C, 32'h304, 32'h0, 4'd7, 2, 32'hA5A5A5A5);
        chk("b2b data", mem_data_out, 32'hA5A5A5A5);
        chk("b2b wb", wb_en_out, 0);

        // Read and write both set: a store.
        run_instr(1, 1, 1, 32'h30, 32'h40, 32'h13572468, 4'd2, 2, 32'hFFFFFFFF);
        chk("rw r_en", mem_r_en_out, 0);
        chk("rw data", mem_data_out, 0);

        // Misaligned load at 0x102.
        run_instr(1, 1, 0, 32'h34, 32'h102, 32'h0, 4'd4, 2, 32'h11223344);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign pulse", misalign_err, 1);
        chk("misalign wb", wb_en_out, 0);
        chk("misalign req", mem_req, 0);
`else
        chk("misalign data", mem_data_out, 32'h11223344);
        chk("misalign pulse", misalign_err, 0);
`endif

        // Stray ack while idle.
        run_instr(1, 0, 0, 32'h38, 32'h99, 32'h0, 4'd1, 0, 32'h55555555);
        chk("stray req", mem_req, 0);
        chk("stray data", mem_data_out, 0);

        // Load with no ack: timeout after TO wait cycles.
        run_instr(1, 1, 0, 32'h3C, 32'h500, 32'h0, 4'd8, NOACK, 0);
        chk("timeout err", mem_err, 1);
        chk("timeout wb", wb_en_out, 0);
        chk("timeout req", mem_req, 0);
        chk("timeout valid", valid_out, 1);
        run_instr(1, 0, 0, 32'h40, 32'h1, 32'h0, 4'd9, NOACK, 0);

        // Reset in WAIT, then a late ack.
        c0 = cyc;
        wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 0;
        pc_in = 32'h60; alu_res_in = 32'h600; st_val_in = 0; dest_in = 4'd7;
        for (int k = 0; k <= 2; k++) set_stall(c0 + k, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            set_req(c0 + k, 1'b1, 1'b0, 32'h600, 32'h0);
            set_out(c0 + k, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        end
        set_stall(c0 + 3, 1'b0);
        set_req(c0 + 3, 1'b0, 1'b0, 0, 0);
        set_out(c0 + 3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        set_req(c0 + 4, 1'b0, 1'b0, 0, 0);
        set_out(c0 + 4, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        err_hi = c0 + 3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        pc_in = 0; alu_res_in = 0; dest_in = 0;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        chk("rst valid", valid_out, 0);
        chk("rst req", mem_req, 0);
        chk("rst pc", pc_out, 0);
        chk("rst err", mem_err, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late ack req", mem_req, 0);
        chk("late ack data", mem_data_out, 0);

        // Recovery after reset.
        run_instr(1, 0, 1, 32'h70, 32'h708, 32'h0F0F0F0F, 4'd1, 2, 0);
        run_instr(1, 0, 0, 32'h74, 32'h0, 32'h0, 4'd0, NOACK, 0);
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
